// File: rtl/mems_raster_gen.sv
// Serpentine raster x/y code generator feeding a serial DAC controller, with per-point settle.
// Optional DAC handshake watchdog and sticky dac_timeout port: define MEMS_RASTER_TIMEOUT_EN.
module mems_raster_gen #(
  parameter logic [7:0]  ON_CODE     = 8'h01,
  parameter logic [11:0] X_MIN       = 12'd0,
  parameter logic [11:0] X_MAX       = 12'd4095,
  parameter logic [11:0] Y_MIN       = 12'd0,
  parameter logic [11:0] Y_MAX       = 12'd4095,
  parameter logic [11:0] PARK_CODE   = 12'd2048,
  parameter logic [15:0] SETTLE_CYC  = 16'd400,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic        clk_40M,
  input  logic        rst_n,
  input  logic [7:0]  command_mems_on,
  input  logic [7:0]  step_length,
  input  logic        dac_finish_flag,
  output logic [11:0] x_dac_data,
  output logic [11:0] y_dac_data,
  output logic        x_start_flag,
  output logic        y_start_flag,
  output logic        line_done,
  output logic        frame_done,
  output logic        busy
`ifdef MEMS_RASTER_TIMEOUT_EN
  ,
  output logic        dac_timeout
`endif
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_LOAD_X  = 4'd1;
  localparam logic [3:0] S_WAIT_X  = 4'd2;
  localparam logic [3:0] S_LOAD_Y  = 4'd3;
  localparam logic [3:0] S_WAIT_Y  = 4'd4;
  localparam logic [3:0] S_SETTLE  = 4'd5;
  localparam logic [3:0] S_STEP    = 4'd6;
  localparam logic [3:0] S_PARK_X  = 4'd7;
  localparam logic [3:0] S_PWAIT_X = 4'd8;
  localparam logic [3:0] S_PARK_Y  = 4'd9;
  localparam logic [3:0] S_PWAIT_Y = 4'd10;

  logic [3:0]  state;
  logic        dir_neg;
  logic [7:0]  step_q;
  logic [15:0] settle_cnt;
  logic        cmd_on;
  logic        halted;
  logic [7:0]  step_eff;

  logic [12:0] x_up;
  logic [11:0] x_dn;
  logic [12:0] lo_lim;
  logic [12:0] y_up;
  logic [11:0] nx;
  logic [11:0] ny;
  logic        x_at_edge;

  assign cmd_on   = (command_mems_on == ON_CODE);
  assign step_eff = (step_length == 8'd0) ? 8'd1 : step_length;
  assign busy     = (state != S_IDLE);

  // Next raster position, computed in 13 bits so the clamps never see a wrapped value.
  // NOTE: every always_comb output gets a value on entry, so no path can infer a latch.
  always_comb begin
    x_up      = {1'b0, x_dac_data} + {5'd0, step_q};
    x_dn      = x_dac_data - {4'd0, step_q};
    lo_lim    = {1'b0, X_MIN} + {5'd0, step_q};
    y_up      = {1'b0, y_dac_data} + {5'd0, step_q};
    nx        = x_dac_data;
    x_at_edge = 1'b0;
    if (dir_neg) begin
      x_at_edge = (x_dac_data == X_MIN);
      nx        = ({1'b0, x_dac_data} < lo_lim) ? X_MIN : x_dn;
    end else begin
      x_at_edge = (x_dac_data == X_MAX);
      nx        = (x_up > {1'b0, X_MAX}) ? X_MAX : x_up[11:0];
    end
    ny = (y_up > {1'b0, Y_MAX}) ? Y_MAX : y_up[11:0];
  end

`ifdef MEMS_RASTER_TIMEOUT_EN
  logic [15:0] wait_cnt;
  logic        in_wait;

  assign in_wait = (state == S_WAIT_X) || (state == S_WAIT_Y) ||
                   (state == S_PWAIT_X) || (state == S_PWAIT_Y);
  assign halted  = dac_timeout;
`else
  logic unused_timeout_cfg;

  assign halted             = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_ff @(posedge clk_40M) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      x_dac_data   <= PARK_CODE;
      y_dac_data   <= PARK_CODE;
      dir_neg      <= 1'b0;
      step_q       <= 8'd1;
      settle_cnt   <= '0;
      x_start_flag <= 1'b0;
      y_start_flag <= 1'b0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;
`ifdef MEMS_RASTER_TIMEOUT_EN
      wait_cnt     <= '0;
      dac_timeout  <= 1'b0;
`endif
    end else begin
      // NOTE: pulses default low here with non-blocking writes; a state below re-raises one for a single cycle.
      x_start_flag <= 1'b0;
      y_start_flag <= 1'b0;
      line_done    <= 1'b0;
      frame_done   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (cmd_on && !halted) begin
            step_q     <= step_eff;
            x_dac_data <= X_MIN;
            y_dac_data <= Y_MIN;
            dir_neg    <= 1'b0;
            state      <= S_LOAD_X;
          end
        end
        S_LOAD_X: begin
          x_start_flag <= 1'b1;
          state        <= S_WAIT_X;
        end
        S_WAIT_X: if (dac_finish_flag) state <= S_LOAD_Y;
        S_LOAD_Y: begin
          y_start_flag <= 1'b1;
          state        <= S_WAIT_Y;
        end
        S_WAIT_Y: begin
          if (dac_finish_flag) begin
            settle_cnt <= '0;
            state      <= (SETTLE_CYC == 16'd0) ? S_STEP : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_CYC - 16'd1) state <= S_STEP;
          else settle_cnt <= settle_cnt + 16'd1;
        end
        S_STEP: begin
          if (!cmd_on) begin
            state <= S_PARK_X;
          end else begin
            state <= S_LOAD_X;
            if (!x_at_edge) begin
              x_dac_data <= nx;
            end else begin
              // The boundary point has just been visited: advance the line, or wrap the frame.
              line_done <= 1'b1;
              if (y_dac_data == Y_MAX) begin
                frame_done <= 1'b1;
                x_dac_data <= X_MIN;
                y_dac_data <= Y_MIN;
                dir_neg    <= 1'b0;
                step_q     <= step_eff;
              end else begin
                dir_neg    <= ~dir_neg;
                y_dac_data <= ny;
              end
            end
          end
        end
        S_PARK_X: begin
          x_dac_data   <= PARK_CODE;
          x_start_flag <= 1'b1;
          state        <= S_PWAIT_X;
        end
        S_PWAIT_X: if (dac_finish_flag) state <= S_PARK_Y;
        S_PARK_Y: begin
          y_dac_data   <= PARK_CODE;
          y_start_flag <= 1'b1;
          state        <= S_PWAIT_Y;
        end
        S_PWAIT_Y: if (dac_finish_flag) state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase

`ifdef MEMS_RASTER_TIMEOUT_EN
      // Watchdog restarts on every wait entry; expiry abandons the scan without parking.
      if (!in_wait) begin
        wait_cnt <= '0;
      end else if (!dac_finish_flag) begin
        if (wait_cnt == TIMEOUT_CYC - 16'd1) begin
          dac_timeout <= 1'b1;
          state       <= S_IDLE;
        end else begin
          wait_cnt <= wait_cnt + 16'd1;
        end
      end
`endif
    end
  end

endmodule
